// File: rtl/issue_queue_age_int.sv
// Age-ordered integer issue queue: group dispatch, tag wakeup, per-port FU-filtered oldest-first select.
// Optional macro IQ_INT_PERF_CNT_EN adds saturating perf_disp_stall / perf_issued counters.
module issue_queue_age_int #(
  parameter int DEPTH      = 16,
  parameter int DISPATCH_W = 4,
  parameter int ISSUE_W    = 3,
  parameter int WB_PORTS   = 3,
  parameter int NSRC       = 2,
  parameter int TAG_W      = 6,
  parameter int PAYLOAD_W  = 64,
  parameter int FU_TYPES   = 4,
  parameter logic [ISSUE_W*FU_TYPES-1:0] PORT_FU_MASK = 12'h953
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [DISPATCH_W-1:0]             disp_valid,
  input  logic [DISPATCH_W*FU_TYPES-1:0]    disp_fu,
  input  logic [DISPATCH_W*NSRC*TAG_W-1:0]  disp_src_tag,
  input  logic [DISPATCH_W*NSRC-1:0]        disp_src_rdy,
  input  logic [DISPATCH_W*PAYLOAD_W-1:0]   disp_payload,
  output logic                              disp_ready,
  input  logic [WB_PORTS-1:0]               wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0]         wb_tag,
  input  logic [ISSUE_W-1:0]                iss_busy,
  output logic [ISSUE_W-1:0]                iss_valid,
  output logic [ISSUE_W*PAYLOAD_W-1:0]      iss_payload,
  output logic [$clog2(DEPTH+1)-1:0]        free_count
`ifdef IQ_INT_PERF_CNT_EN
  ,
  output logic [31:0]                       perf_disp_stall,
  output logic [31:0]                       perf_issued
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
  localparam int LW = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1;

  logic [DEPTH-1:0]                        valid_q, valid_d;
  logic [DEPTH-1:0][DEPTH-1:0]             older_q, older_d;
  logic [DEPTH-1:0][FU_TYPES-1:0]          fu_q;
  logic [DEPTH-1:0][NSRC-1:0][TAG_W-1:0]   tag_q;
  logic [DEPTH-1:0][NSRC-1:0]              rdy_q;
  logic [DEPTH-1:0][PAYLOAD_W-1:0]         pay_q;

  logic [DISPATCH_W-1:0][FU_TYPES-1:0]        lane_fu;
  logic [DISPATCH_W-1:0][NSRC-1:0][TAG_W-1:0] lane_tag;
  logic [DISPATCH_W-1:0][NSRC-1:0]            lane_rdy;
  logic [DISPATCH_W-1:0][PAYLOAD_W-1:0]       lane_pay;
  logic [WB_PORTS-1:0][TAG_W-1:0]             wb_tag_a;
  logic [DEPTH-1:0][NSRC-1:0]                 rdy_wake;
  logic [DEPTH-1:0]                           ent_rdy;

  logic [DEPTH-1:0]            free_m, claimed, wr_en;
  logic [DEPTH-1:0][LW-1:0]    wr_lane;
  logic [DEPTH-1:0][DEPTH-1:0] wr_row;
  logic                        found;
  logic [IW-1:0]               idx;
  logic [CW:0]                 acc_cnt, iss_cnt;

  logic [DEPTH-1:0]            granted, cand;
  logic                        hit;
  int                          fc_sum;
  logic [CW-1:0]               free_next;

  assign lane_fu  = disp_fu;
  assign lane_tag = disp_src_tag;
  assign lane_pay = disp_payload;
  assign wb_tag_a = wb_tag;

  function automatic logic woken(input logic [TAG_W-1:0] tag,
                                 input logic [WB_PORTS-1:0] v,
                                 input logic [WB_PORTS-1:0][TAG_W-1:0] t);
    logic m;
    m = 1'b0;
    for (int k = 0; k < WB_PORTS; k++)
      if (v[k] && (t[k] == tag)) m = 1'b1;
    return m;
  endfunction

  // Wakeup covers both resident entries and lanes being written this edge
  always_comb begin
    lane_rdy = '0;
    rdy_wake = '0;
    for (int l = 0; l < DISPATCH_W; l++)
      for (int s = 0; s < NSRC; s++)
        lane_rdy[l][s] = disp_src_rdy[l*NSRC+s] | woken(lane_tag[l][s], wb_valid, wb_tag_a);
    for (int i = 0; i < DEPTH; i++)
      for (int s = 0; s < NSRC; s++)
        rdy_wake[i][s] = rdy_q[i][s] | woken(tag_q[i][s], wb_valid, wb_tag_a);
  end

  always_comb begin
    ent_rdy = '0;
    for (int i = 0; i < DEPTH; i++)
      ent_rdy[i] = valid_q[i] & (&rdy_q[i]);
  end

  assign disp_ready = (free_count >= CW'(DISPATCH_W)) & ~flush;

  // Lanes in order take the lowest free entry; each row records every entry older than it
  always_comb begin
    free_m  = ~valid_q;
    claimed = '0;
    wr_en   = '0;
    wr_lane = '0;
    wr_row  = '0;
    acc_cnt = '0;
    found   = 1'b0;
    idx     = '0;
    for (int l = 0; l < DISPATCH_W; l++) begin
      found = 1'b0;
      idx   = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
        if (free_m[i]) begin
          found = 1'b1;
          idx   = IW'(i);
        end
      end
      if (disp_ready && disp_valid[l] && found) begin
        wr_en[idx]   = 1'b1;
        wr_lane[idx] = LW'(l);
        wr_row[idx]  = valid_q | claimed;
        claimed[idx] = 1'b1;
        free_m[idx]  = 1'b0;
        acc_cnt      = acc_cnt + (CW+1)'(1);
      end
    end
  end

  // Candidate is oldest when no other candidate is marked older in its row
  always_comb begin
    granted     = '0;
    cand        = '0;
    hit         = 1'b0;
    iss_valid   = '0;
    iss_payload = '0;
    iss_cnt     = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++)
        cand[i] = ent_rdy[i] & ~granted[i] & (|(fu_q[i] & PORT_FU_MASK[p*FU_TYPES +: FU_TYPES]));
      if (!flush && !iss_busy[p]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!hit && cand[i] && ((cand & older_q[i]) == '0)) begin
            hit          = 1'b1;
            granted[i]   = 1'b1;
            iss_valid[p] = 1'b1;
            iss_payload[p*PAYLOAD_W +: PAYLOAD_W] = pay_q[i];
            iss_cnt      = iss_cnt + (CW+1)'(1);
          end
        end
      end
    end
  end

  always_comb begin
    valid_d = (valid_q & ~granted) | wr_en;
    older_d = older_q;
    for (int i = 0; i < DEPTH; i++)
      if (wr_en[i]) older_d[i] = wr_row[i];
    for (int i = 0; i < DEPTH; i++)
      older_d[i] = older_d[i] & ~granted;
    fc_sum    = int'(free_count) - int'(acc_cnt) + int'(iss_cnt);
    free_next = CW'(fc_sum);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      older_q    <= '0;
      free_count <= CW'(DEPTH);
    end else if (flush) begin
      valid_q    <= '0;
      older_q    <= '0;
      free_count <= CW'(DEPTH);
    end else begin
      valid_q    <= valid_d;
      older_q    <= older_d;
      free_count <= free_next;
    end
  end

  // Entry contents are qualified by valid_q and need no reset
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        fu_q[i]  <= lane_fu[wr_lane[i]];
        tag_q[i] <= lane_tag[wr_lane[i]];
        rdy_q[i] <= lane_rdy[wr_lane[i]];
        pay_q[i] <= lane_pay[wr_lane[i]];
      end else begin
        rdy_q[i] <= rdy_wake[i];
      end
    end
  end

  a_free_hi: assert property (@(posedge clock) disable iff (!reset) (fc_sum <= DEPTH));
  a_free_lo: assert property (@(posedge clock) disable iff (!reset) (fc_sum >= 0));

`ifdef IQ_INT_PERF_CNT_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_disp_stall <= '0;
      perf_issued     <= '0;
    end else begin
      perf_disp_stall <= sat_add(perf_disp_stall, {31'd0, (|disp_valid) & ~disp_ready});
      perf_issued     <= sat_add(perf_issued, 32'(iss_cnt));
    end
  end
`endif

endmodule

// File: tb/tb_issue_queue_age_int.sv
// Directed bench for issue_queue_age_int: dispatch, wakeup, select priority, full, flush and reset.
module tb_issue_queue_age_int;
  localparam logic [3:0] ALU = 4'b0001;
  localparam logic [3:0] BR  = 4'b0010;
  localparam logic [3:0] MUL = 4'b0100;
  localparam logic [3:0] DIV = 4'b1000;

  logic          clock, reset, flush;
  logic [3:0]    disp_valid;
  logic [15:0]   disp_fu;
  logic [47:0]   disp_src_tag;
  logic [7:0]    disp_src_rdy;
  logic [255:0]  disp_payload;
  logic          disp_ready;
  logic [2:0]    wb_valid;
  logic [17:0]   wb_tag;
  logic [2:0]    iss_busy;
  logic [2:0]    iss_valid;
  logic [191:0]  iss_payload;
  logic [4:0]    free_count;
`ifdef IQ_INT_PERF_CNT_EN
  logic [31:0]   perf_disp_stall, perf_issued;
`endif

  int checks   = 0;
  int failures = 0;

  issue_queue_age_int dut (
    .clock(clock), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_fu(disp_fu), .disp_src_tag(disp_src_tag),
    .disp_src_rdy(disp_src_rdy), .disp_payload(disp_payload), .disp_ready(disp_ready),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .iss_busy(iss_busy),
    .iss_valid(iss_valid), .iss_payload(iss_payload), .free_count(free_count)
`ifdef IQ_INT_PERF_CNT_EN
    , .perf_disp_stall(perf_disp_stall), .perf_issued(perf_issued)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ipay(input int p);
    return iss_payload[p*64 +: 64];
  endfunction

  task automatic idle();
    flush = 1'b0; disp_valid = '0; disp_fu = '0; disp_src_tag = '0;
    disp_src_rdy = '0; disp_payload = '0; wb_valid = '0; wb_tag = '0; iss_busy = '0;
  endtask

  task automatic lane(input int l, input logic [3:0] fu, input logic [5:0] t0,
                      input logic r0, input logic [63:0] pay);
    disp_valid[l]                  = 1'b1;
    disp_fu[l*4 +: 4]              = fu;
    disp_src_tag[(l*2)*6 +: 6]     = t0;
    disp_src_tag[(l*2+1)*6 +: 6]   = 6'd0;
    disp_src_rdy[l*2]              = r0;
    disp_src_rdy[l*2+1]            = 1'b1;
    disp_payload[l*64 +: 64]       = pay;
  endtask

  task automatic wake(input int k, input logic [5:0] t);
    wb_valid[k]      = 1'b1;
    wb_tag[k*6 +: 6] = t;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (3) @(posedge clock);
    #1;
    check("rst_free", free_count, 16);
    check("rst_ready", disp_ready, 1);
    check("rst_iss", iss_valid, 0);
    reset = 1'b1;
    tick();

    // four FU classes in one group
    lane(0, ALU, 0, 1, 64'h100); lane(1, BR, 0, 1, 64'h101);
    lane(2, MUL, 0, 1, 64'h102); lane(3, DIV, 0, 1, 64'h103);
    #1 check("grp_ready", disp_ready, 1);
    tick(); idle();
    #1;
    check("grp_iss1", iss_valid, 3'b111);
    check("grp_p0", ipay(0), 64'h100);
    check("grp_p1", ipay(1), 64'h102);
    check("grp_p2", ipay(2), 64'h103);
    check("grp_free1", free_count, 12);
    tick();
    check("grp_iss2", iss_valid, 3'b001);
    check("grp_p0_br", ipay(0), 64'h101);
    check("grp_p1_zero", ipay(1), 64'h0);
    check("grp_free2", free_count, 15);
    tick();
    check("grp_empty", iss_valid, 0);
    check("grp_free3", free_count, 16);

    // wakeup coinciding with dispatch
    lane(0, ALU, 5, 0, 64'h200); wake(0, 5);
    #1 check("wk_none", iss_valid, 0);
    tick(); idle();
    #1;
    check("wk_iss", iss_valid, 3'b001);
    check("wk_pay", ipay(0), 64'h200);
    tick();
    check("wk_free", free_count, 16);

    // fill with blocked uops down to free_count=3
    for (int g = 0; g < 3; g++) begin
      for (int l = 0; l < 4; l++) lane(l, ALU, 6'(20 + 4*g + l), 0, 64'(32'h300 + 4*g + l));
      tick();
    end
    idle();
    lane(2, ALU, 32, 0, 64'h30c);
    tick(); idle();
    #1;
    check("full_free", free_count, 3);
    check("full_ready", disp_ready, 0);
    check("full_iss", iss_valid, 0);
    lane(0, ALU, 33, 1, 64'h3ff);
    #1 check("full_partial", disp_ready, 0);
    tick();
    check("full_hold", free_count, 3);
    wake(0, 25);
    tick();
    check("full_iss1", iss_valid, 3'b001);
    check("full_pay", ipay(0), 64'h305);
    check("full_ready2", disp_ready, 0);
    idle();
    tick();
    check("full_free4", free_count, 4);
    check("full_ready3", disp_ready, 1);
    check("full_noiss", iss_valid, 0);

    // flush with a full queue and a dispatching group
    for (int l = 0; l < 4; l++) lane(l, ALU, 0, 1, 64'(32'h400 + l));
    tick(); idle();
    #1;
    check("fl_free0", free_count, 0);
    check("fl_iss_pre", iss_valid, 3'b111);
    check("fl_p0", ipay(0), 64'h400);
    check("fl_p2", ipay(2), 64'h402);
    flush = 1'b1;
    for (int l = 0; l < 4; l++) lane(l, ALU, 0, 1, 64'(32'h410 + l));
    #1;
    check("fl_iss", iss_valid, 0);
    check("fl_ready", disp_ready, 0);
    tick(); idle();
    #1;
    check("fl_free", free_count, 16);
    check("fl_ready2", disp_ready, 1);
    check("fl_empty", iss_valid, 0);
    wake(0, 20);
    tick(); idle();
    check("fl_stale", iss_valid, 0);

    // busy port 0 pushes the oldest ALU to port 1
    lane(0, ALU, 0, 1, 64'h500); lane(1, ALU, 0, 1, 64'h501);
    tick(); idle(); iss_busy = 3'b001;
    #1;
    check("busy_iss", iss_valid, 3'b110);
    check("busy_p0", ipay(0), 64'h0);
    check("busy_p1", ipay(1), 64'h500);
    check("busy_p2", ipay(2), 64'h501);
    iss_busy = 3'b000;
    tick();
    check("busy_free", free_count, 16);

    // age beats index after an entry is recycled
    lane(0, ALU, 41, 0, 64'h700); lane(1, ALU, 42, 0, 64'h701);
    tick(); idle(); wake(0, 41);
    #1 check("age_wait", iss_valid, 0);
    tick(); idle();
    #1;
    check("age_iss0", iss_valid, 3'b001);
    check("age_pay0", ipay(0), 64'h700);
    tick();
    lane(0, ALU, 0, 1, 64'h702); wake(0, 42); iss_busy = 3'b110;
    #1 check("age_none", iss_valid, 0);
    tick(); idle(); iss_busy = 3'b110;
    #1;
    check("age_old", ipay(0), 64'h701);
    check("age_iss1", iss_valid, 3'b001);
    tick();
    check("age_young", ipay(0), 64'h702);
    iss_busy = 3'b000;
    tick();
    check("age_free", free_count, 16);

    // DIV waits for its only port
    lane(0, DIV, 0, 1, 64'h800);
    tick(); idle(); iss_busy = 3'b100;
    for (int c = 0; c < 5; c++) begin
      #1 check("div_hold", iss_valid, 0);
      tick();
    end
    iss_busy = 3'b000;
    #1;
    check("div_iss", iss_valid, 3'b100);
    check("div_pay", ipay(2), 64'h800);
    tick();
    check("div_free", free_count, 16);

`ifdef IQ_INT_PERF_CNT_EN
    check("perf_stall", perf_disp_stall, 3);
    check("perf_issued", perf_issued, 12);
`endif

    // asynchronous reset with ready uops resident
    for (int l = 0; l < 4; l++) lane(l, ALU, 0, 1, 64'(32'h900 + l));
    tick(); idle();
    #1 check("rr_pre", iss_valid, 3'b111);
    reset = 1'b0;
    #1;
    check("rr_iss", iss_valid, 0);
    check("rr_free", free_count, 16);
    check("rr_ready", disp_ready, 1);
`ifdef IQ_INT_PERF_CNT_EN
    check("rr_perf_st", perf_disp_stall, 0);
    check("rr_perf_is", perf_issued, 0);
`endif
    #2 reset = 1'b1;
    tick();
    check("rr_post_iss", iss_valid, 0);
    check("rr_post_free", free_count, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
